ksa_swap: RTL
=============

# ksa_swap

Second stage of the RC4 key-scheduling pipeline. Once the init stage has filled the 256×8 S memory with S[i] = i, this block runs the KSA permutation loop over that memory:
- for i = 0..255: j = j + S[i] + key[i mod KEY_BYTES]; swap S[i] and S[j].

It drives the same single-port S memory through the parent's port mux, and its `done` output starts the downstream PRGA/decrypt stage.

## Interface
- `KEY_BYTES`, default 3: secret key length in bytes; key width is 8×KEY_BYTES.
- `CLOCK_50`, in, 1: sole clock, rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: one-cycle request; sampled only in IDLE or DONE.
- `secret_key`, in, 8×KEY_BYTES: key; byte 0 is the MSB byte (`[23:16]` for default).
- `q`, in, 8: S memory read data.
- `address`, out, 8: S memory address, registered.
- `data`, out, 8: S memory write data, registered.
- `wren`, out, 1: S memory write enable, registered.
- `done`, out, 1: level; high while in DONE.

## Operation
- Shared registers: `i` (8b), `j` (8b), `si` (8b), `sj` (8b), `kidx` (0..KEY_BYTES-1), `key_q` (key latched at start).
- States and transitions:
  - IDLE → RD_I when `start`. On that edge: i = 0, j = 0, kidx = 0, `key_q` = `secret_key`.
  - RD_I → WT_I: address = i, wren = 0.
  - WT_I → RD_J: capture si = q, and j = j + q + key_q[kidx], mod 256.
  - RD_J → WT_J: address = j, wren = 0.
  - WT_J → WR_I: capture sj = q.
  - WR_I → WR_J: address = i, data = sj, wren = 1.
  - WR_J: address = j, data = si, wren = 1. At the end of WR_J:
    - if i == 255 → DONE;
    - else i = i + 1, kidx = (kidx + 1) wraps at KEY_BYTES, → RD_I.
  - DONE: wren = 0 and `done` = 1. `start` re-enters RD_I with the full reinitialisation described for IDLE.
- Arithmetic: all sums are 8-bit and wrap modulo 256. `kidx` is a counter, not a modulo operator.
- i == j: WR_I and WR_J both write the same byte with the same value; no special case.
- `start` outside IDLE/DONE is ignored. `secret_key` changes after the start edge have no effect.
- `address`, `data` and `wren` hold their last values in IDLE and DONE, except wren = 0.
- Reset: state = IDLE, i = j = si = sj = kidx = 0, `key_q` = 0. Outputs: address = 0, data = 0, wren = 0, done = 0. The reset is immediate and asynchronous; a reset mid-loop abandons the partial permutation, and no write is issued after reset asserts.

## Timing
- All outputs are registered and take the value listed for a state on the edge entering that state.
- Memory contract: the RAM registers address, data and wren on the edge ending the state that drives them. Read data `q` is valid throughout the following state and is sampled at that state's ending edge.
- 6 cycles per iteration; 1536 cycles for the full loop.
- `done` rises exactly 1536 edges after the edge that samples `start`.
- Exactly one memory write per WR_I and per WR_J; no reads and writes overlap.

## Structure
- Package `ksa_pkg` holds:
  - `ksa_state_t` enum: IDLE, RD_I, WT_I, RD_J, WT_J, WR_I, WR_J, DONE;
  - `S_SIZE` = 256;
  - `KEY_BYTES_DEFAULT` = 3.
  It is shared with the init and PRGA stages.
- One natural sub-module: `ksa_key_select`, a combinational byte mux from `key_q` and `kidx` to an 8-bit key byte. Everything else lives in `ksa_swap`.
- Port arbitration between init, swap and PRGA stays in the parent.

## Test plan
- **Key 24'h000249:**
  - S preloaded identity; pulse `start` → iteration 0 writes S[0] = 0 twice (j = 0).
  - Iteration 1: j = 0 + 1 + 0x02 = 3, writes S[1] = 3, then S[3] = 1.
- **Full run, same key:** `done` rises 1536 cycles after `start`; final S is a permutation of 0..255 with each value exactly once; contents match a software RC4 KSA model byte-for-byte.
- **Key 24'h000000 with identity S:** iteration 0 exercises i == j (both writes are address 0, data 0); the full run matches the model.
- **Reset mid-run:** assert `reset` at cycle 700 → wren drops to 0 asynchronously and all outputs return to reset values. Re-`start` with a freshly initialised S → the result matches the model.
- **`start` pulses while busy:** pulses at cycles 10 and 900 are ignored and cycle count stays 1536. `start` in DONE restarts the loop and `done` drops on the next edge.
- **Key change after start:** change `secret_key` one cycle after `start` → the result matches the model for the original key.

Source files
------------

// File: rtl/ksa_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ksa_pkg
// Description : Types and constants shared by the RC4 key-scheduling stages
//               (init, swap and PRGA). Holds the KSA state encoding, the S
//               memory depth, the default key length and a helper that
//               sizes the key-byte index counter.
// Revision    : 1.0 - initial release
// ============================================================================
package ksa_pkg;

   localparam int S_SIZE            = 256;
   localparam int KEY_BYTES_DEFAULT = 3;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RD_I = 3'd1,
      WT_I = 3'd2,
      RD_J = 3'd3,
      WT_J = 3'd4,
      WR_I = 3'd5,
      WR_J = 3'd6,
      DONE = 3'd7
   } ksa_state_t;

   // Width of a counter that indexes key bytes 0..n-1. Never less than one
   // bit, so a single-byte key still gets a legal vector.
   function automatic int kidx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage : ksa_pkg
`default_nettype wire

// File: rtl/ksa_key_select.sv
`default_nettype none
// ============================================================================
// Module      : ksa_key_select
// Description : Combinational byte mux that picks key byte kidx_i out of the
//               latched key. Byte 0 is the most significant byte of key_i.
// Ports       : key_i      - latched secret key, 8*KEY_BYTES bits
//               kidx_i     - key byte index, 0..KEY_BYTES-1
//               key_byte_o - selected key byte
// Revision    : 1.0 - initial release
// ============================================================================
module ksa_key_select
   import ksa_pkg::*;
#(
   parameter int KEY_BYTES = KEY_BYTES_DEFAULT,
   parameter int KIDX_W    = kidx_width(KEY_BYTES)
) (
   input  logic [8*KEY_BYTES-1:0] key_i,
   input  logic [KIDX_W-1:0]      kidx_i,
   output logic [7:0]             key_byte_o
);

   // Index values past KEY_BYTES-1 never occur; they decode to zero.
   always_comb begin
      key_byte_o = 8'd0;
      for (int b = 0; b < KEY_BYTES; b++) begin
         if (kidx_i == KIDX_W'(b)) begin
            key_byte_o = key_i[8*(KEY_BYTES-1-b) +: 8];
         end
      end
   end

endmodule : ksa_key_select
`default_nettype wire

// File: rtl/ksa_swap.sv
`default_nettype none
// ============================================================================
// Module      : ksa_swap
// Description : RC4 KSA permutation loop over a 256x8 single-port S memory
//               that already holds S[i] = i. For i = 0..255 it computes
//               j += S[i] + key[i mod KEY_BYTES] and swaps S[i] and S[j],
//               taking six cycles per iteration (1536 for the full loop).
// Ports       : CLOCK_50   - clock, rising edge
//               reset      - asynchronous active-high reset
//               start      - one-cycle request, honoured in IDLE or DONE only
//               secret_key - key, byte 0 in the MSBs, latched at start
//               q          - S memory read data
//               address    - S memory address (registered)
//               data       - S memory write data (registered)
//               wren       - S memory write enable (registered)
//               done       - high while the permutation is complete
// Revision    : 1.0 - initial release
// ============================================================================
module ksa_swap
   import ksa_pkg::*;
#(
   parameter int KEY_BYTES = KEY_BYTES_DEFAULT
) (
   input  logic                   CLOCK_50,
   input  logic                   reset,
   input  logic                   start,
   input  logic [8*KEY_BYTES-1:0] secret_key,
   input  logic [7:0]             q,
   output logic [7:0]             address,
   output logic [7:0]             data,
   output logic                   wren,
   output logic                   done
);

   localparam int                KIDX_W    = kidx_width(KEY_BYTES);
   localparam logic [7:0]        I_LAST    = 8'(S_SIZE - 1);
   localparam logic [KIDX_W-1:0] KIDX_LAST = KIDX_W'(KEY_BYTES - 1);

   ksa_state_t               state_q, state_d;
   logic [7:0]               i_q, i_d;
   logic [7:0]               j_q, j_d;
   logic [7:0]               si_q, si_d;
   logic [KIDX_W-1:0]        kidx_q, kidx_d;
   logic [8*KEY_BYTES-1:0]   key_q, key_d;
   logic [7:0]               addr_q, addr_d;
   // data_q also serves as the sj register: S[j] is captured straight into
   // it on the edge entering WR_I, which is exactly where it must be driven.
   logic [7:0]               data_q, data_d;
   logic                     wren_q, wren_d;
   logic                     done_q, done_d;

   logic [7:0]               key_byte;
   logic [7:0]               j_next;

   ksa_key_select #(
      .KEY_BYTES (KEY_BYTES),
      .KIDX_W    (KIDX_W)
   ) u_key_select (
      .key_i      (key_q),
      .kidx_i     (kidx_q),
      .key_byte_o (key_byte)
   );

   // q holds S[i] during WT_I; all terms wrap modulo 256.
   assign j_next = j_q + q + key_byte;

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         i_q     <= 8'd0;
         j_q     <= 8'd0;
         si_q    <= 8'd0;
         kidx_q  <= '0;
         key_q   <= '0;
         addr_q  <= 8'd0;
         data_q  <= 8'd0;
         wren_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         j_q     <= j_d;
         si_q    <= si_d;
         kidx_q  <= kidx_d;
         key_q   <= key_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         wren_q  <= wren_d;
         done_q  <= done_d;
      end
   end

   // Outputs are computed for the state being entered, so each registered
   // output carries that state's value for the whole state.
   always_comb begin
      state_d = state_q;
      i_d     = i_q;
      j_d     = j_q;
      si_d    = si_q;
      kidx_d  = kidx_q;
      key_d   = key_q;
      addr_d  = addr_q;
      data_d  = data_q;
      wren_d  = wren_q;
      done_d  = done_q;

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d = RD_I;
               i_d     = 8'd0;
               j_d     = 8'd0;
               kidx_d  = '0;
               key_d   = secret_key;
               addr_d  = 8'd0;
               wren_d  = 1'b0;
               done_d  = 1'b0;
            end
         end
         RD_I: begin
            state_d = WT_I;
         end
         WT_I: begin
            state_d = RD_J;
            si_d    = q;
            j_d     = j_next;
            addr_d  = j_next;
            wren_d  = 1'b0;
         end
         RD_J: begin
            state_d = WT_J;
         end
         WT_J: begin
            state_d = WR_I;
            addr_d  = i_q;
            data_d  = q;
            wren_d  = 1'b1;
         end
         WR_I: begin
            state_d = WR_J;
            addr_d  = j_q;
            data_d  = si_q;
            wren_d  = 1'b1;
         end
         WR_J: begin
            wren_d = 1'b0;
            if (i_q == I_LAST) begin
               state_d = DONE;
               done_d  = 1'b1;
            end else begin
               state_d = RD_I;
               i_d     = i_q + 8'd1;
               addr_d  = i_q + 8'd1;
               kidx_d  = (kidx_q == KIDX_LAST) ? '0 : kidx_q + KIDX_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            wren_d  = 1'b0;
         end
      endcase
   end

   assign address = addr_q;
   assign data    = data_q;
   assign wren    = wren_q;
   assign done    = done_q;

endmodule : ksa_swap
`default_nettype wire
